// File: rtl/sum_mem_writer.sv
// Fills a single-port memory with a Galois LFSR sequence and keeps a running checksum of accepted words.
// One word per accepted cycle; wr_ready low holds the request, address, data and sum until accepted.
module sum_mem_writer #(
  parameter int          AWIDTH = 10,
  parameter int          DWIDTH = 32,
  parameter int          DEPTH  = 1024,
  parameter logic [31:0] SEED   = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       size,
  input  logic              wr_ready,
  output logic              we,
  output logic [AWIDTH-1:0] waddr,
  output logic [DWIDTH-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       sum
);

  localparam logic [31:0] POLY    = 32'h8020_0003;
  localparam logic [31:0] DEPTH32 = 32'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         len_q, len_d;
  logic [AWIDTH-1:0]   cnt_q, cnt_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [31:0]         sum_q, sum_d;
  logic                last_word;

  assign last_word = (32'(cnt_q) == (len_q - 32'd1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d   = (size > DEPTH32) ? DEPTH32 : size;
          lfsr_d  = SEED;
          sum_d   = 32'd0;
          cnt_d   = '0;
          state_d = (size == 32'd0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_ready) begin
          sum_d  = sum_q + 32'(lfsr_q[DWIDTH-1:0]);
          lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 32'd0);
          // The counter stops on the last word so waddr holds len-1 in DONE.
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= 32'd0;
      cnt_q   <= '0;
      lfsr_q  <= 32'd0;
      sum_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      sum_q   <= sum_d;
    end
  end

  assign we    = (state_q == S_WRITE);
  assign busy  = (state_q == S_WRITE);
  assign done  = (state_q == S_DONE);
  assign waddr = cnt_q;
  assign wdata = lfsr_q[DWIDTH-1:0];
  assign sum   = sum_q;

endmodule

// File: tb/tb_sum_mem_writer.sv
// Directed bench for sum_mem_writer: fixed fills, stalls, zero/oversize lengths, ignored start, async reset.
`define CHK(tag, obs, exp) begin checks++; assert (32'(obs) === 32'(exp)) else begin failures++; $error("FAIL %s observed=%0h expected=%0h", tag, 32'(obs), 32'(exp)); end end

module tb_sum_mem_writer;
  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] size;
  logic        wr_ready;
  logic        we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] sum;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp4 [4] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};

  sum_mem_writer #(.AWIDTH(10), .DWIDTH(32), .DEPTH(1024), .SEED(32'h0000_0001)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .size(size), .wr_ready(wr_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .sum(sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // size=4 with wr_ready high; optionally pulses start (size=2) during write index pulse_at.
  task automatic fill4(input int pulse_at);
    size  = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      `CHK("fill4_we", we, 1'b1)
      `CHK("fill4_addr", waddr, i)
      `CHK("fill4_data", wdata, exp4[i])
      `CHK("fill4_done_early", done, 1'b0)
      if (i == pulse_at) begin
        start = 1'b1;
        size  = 32'd2;
      end
      tick();
      start = 1'b0;
      size  = 32'd4;
    end
    `CHK("fill4_done", done, 1'b1)
    `CHK("fill4_we_low", we, 1'b0)
    `CHK("fill4_busy_low", busy, 1'b0)
    `CHK("fill4_sum", sum, 32'hA068_0007)
    `CHK("fill4_last_addr", waddr, 10'd3)
  endtask

  initial begin
    logic [31:0] m;
    logic [31:0] msum;
    int          n;
    int          acc;
    int          bad;
    int          last_addr;

    reset_n  = 1'b0;
    start    = 1'b0;
    size     = 32'd0;
    wr_ready = 1'b1;
    #12;
    `CHK("rst_we", we, 1'b0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_waddr", waddr, 10'd0)
    `CHK("rst_wdata", wdata, 32'd0)
    `CHK("rst_sum", sum, 32'd0)
    reset_n = 1'b1;
    tick();

    // Basic fill.
    fill4(-1);

    // Alternating stalls: wr_ready low on even cycles, each word held two cycles.
    size  = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      wr_ready = (c % 2 == 1);
      `CHK("stall_we", we, 1'b1)
      `CHK("stall_addr", waddr, c / 2)
      `CHK("stall_data", wdata, exp4[c/2])
      `CHK("stall_done_early", done, 1'b0)
      tick();
    end
    wr_ready = 1'b1;
    `CHK("stall_done", done, 1'b1)
    `CHK("stall_sum", sum, 32'hA068_0007)

    // Zero-length fill, then size 3.
    size  = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    `CHK("zero_done", done, 1'b1)
    `CHK("zero_we", we, 1'b0)
    `CHK("zero_sum", sum, 32'd0)
    `CHK("zero_waddr", waddr, 10'd0)
    size  = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    `CHK("three_we", we, 1'b1)
    tick();
    tick();
    `CHK("three_done_early", done, 1'b0)
    tick();
    `CHK("three_done", done, 1'b1)
    `CHK("three_sum", sum, 32'h4050_0006)

    // Oversize fill clipped to DEPTH, checked against a software LFSR.
    m    = 32'h0000_0001;
    msum = 32'd0;
    n    = 0;
    acc  = 0;
    bad  = 0;
    last_addr = -1;
    size  = 32'd5000;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && n < 2000) begin
      if (we) begin
        if (wdata !== m || waddr !== 10'(acc)) bad++;
        msum = msum + m;
        m    = (m >> 1) ^ (m[0] ? 32'h8020_0003 : 32'd0);
        last_addr = int'(waddr);
        acc++;
      end
      tick();
      n++;
    end
    `CHK("big_writes", acc, 1024)
    `CHK("big_cycles", n, 1024)
    `CHK("big_last_addr", last_addr, 1023)
    `CHK("big_seq_errors", bad, 0)
    `CHK("big_sum", sum, msum)
    `CHK("big_done", done, 1'b1)

    // start during WRITE is ignored.
    fill4(1);

    // Asynchronous reset after two accepted writes.
    size  = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    `CHK("pre_rst_addr", waddr, 10'd2)
    #2;
    reset_n = 1'b0;
    #1;
    `CHK("arst_we", we, 1'b0)
    `CHK("arst_busy", busy, 1'b0)
    `CHK("arst_waddr", waddr, 10'd0)
    `CHK("arst_wdata", wdata, 32'd0)
    `CHK("arst_sum", sum, 32'd0)
    `CHK("arst_done", done, 1'b0)
    #2;
    reset_n = 1'b1;
    tick();
    fill4(-1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
